// File: rtl/crc_serial_engine.sv
// crc_serial_engine: parametrised serial CRC engine.
// Accumulates a CRC over an LSB-first serial bit stream, serialises the
// finished CRC MSB-first on request, and flags a good packet by comparing
// the register against a residue constant.
// Optional feature macro: CRC_BIT_COUNT_EN adds the bit_cnt output.
module crc_serial_engine #(
    parameter int unsigned WIDTH   = 16,
    parameter logic [31:0] POLY    = 32'h0000_8005,
    parameter logic [31:0] INIT    = 32'h0000_0000,
    parameter logic [31:0] XOR_OUT = 32'h0000_0000,
    parameter logic [31:0] RESIDUE = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             din,
    input  logic             shiftEn,
    input  logic             clear,
    input  logic             emit,
    output logic [WIDTH-1:0] crc,
    output logic             crc_ok,
    output logic             dout,
    output logic             dout_valid,
    output logic             emit_done
`ifdef CRC_BIT_COUNT_EN
    ,
    output logic [15:0]      bit_cnt
`endif
);

    localparam logic [WIDTH-1:0] POLY_W    = POLY[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INIT_W    = INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] XOR_W     = XOR_OUT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESIDUE_W = RESIDUE[WIDTH-1:0];
    localparam int unsigned      CNT_W     = $clog2(WIDTH + 1);

    typedef enum logic {ACCUM, EMIT} state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   crc_reg;
    logic [WIDTH-1:0]   next_reg;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   shadow;
    logic [CNT_W-1:0]   emit_cnt;
    logic               fb;
    logic               accum_step;
    logic               last_bit;

    // Register update for one accumulated bit, and detection of the final emitted bit.
    always_comb begin
        fb         = din ^ crc_reg[WIDTH-1];
        shifted    = {crc_reg[WIDTH-2:0], 1'b0} ^ (fb ? POLY_W : '0);
        accum_step = (state == ACCUM) && shiftEn;
        next_reg   = accum_step ? shifted : crc_reg;
        last_bit   = (state == EMIT) && shiftEn && (emit_cnt == CNT_W'(1));
    end

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= ACCUM;
        else       state <= state_next;
    end

    // Next-state logic: clear wins, emit is only honoured while accumulating.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (emit)     state_next = EMIT;
                EMIT:    if (last_bit) state_next = ACCUM;
                default: state_next = ACCUM;
            endcase
        end
    end

    // Datapath: CRC register, emit shadow, emit counter and completion pulse.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            crc_reg   <= INIT_W;
            shadow    <= '0;
            emit_cnt  <= '0;
            emit_done <= 1'b0;
        end else begin
            emit_done <= 1'b0;
            if (clear) begin
                crc_reg  <= INIT_W;
                emit_cnt <= '0;
            end else if (state == ACCUM) begin
                crc_reg <= next_reg;
                if (emit) begin
                    // Snapshot includes a bit accumulated on this same edge.
                    shadow   <= next_reg ^ XOR_W;
                    emit_cnt <= CNT_W'(WIDTH);
                end
            end else if (shiftEn) begin
                shadow   <= {shadow[WIDTH-2:0], 1'b0};
                emit_cnt <= emit_cnt - CNT_W'(1);
                if (last_bit) begin
                    crc_reg   <= INIT_W;
                    emit_done <= 1'b1;
                end
            end
        end
    end

    // Outputs derived from state and registers.
    always_comb begin
        crc        = crc_reg ^ XOR_W;
        crc_ok     = (crc_reg == RESIDUE_W);
        dout_valid = (state == EMIT);
        dout       = (state == EMIT) ? shadow[WIDTH-1] : 1'b0;
    end

`ifdef CRC_BIT_COUNT_EN
    // Saturating count of data bits accumulated since reset, clear or emit completion.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            bit_cnt <= '0;
        end else if (clear || last_bit) begin
            bit_cnt <= '0;
        end else if (accum_step && (bit_cnt != 16'hFFFF)) begin
            bit_cnt <= bit_cnt + 16'd1;
        end
    end
`endif

endmodule
